// File: rtl/audio_dcblock_sdm_if.sv
// Sample, gain and bitstream signals between the NES core and the audio output stage.
interface audio_dcblock_sdm_if;
    logic        [15:0] sample_in;
    logic               sample_ce;
    logic        [3:0]  volume;
    logic               mute;
    logic signed [15:0] level_out;
    logic               clip;
    logic               dac_out;

    modport master (
        output sample_in,
        output sample_ce,
        output volume,
        output mute,
        input  level_out,
        input  clip,
        input  dac_out
    );

    modport slave (
        input  sample_in,
        input  sample_ce,
        input  volume,
        input  mute,
        output level_out,
        output clip,
        output dac_out
    );
endinterface

// File: rtl/audio_dcblock_sdm.sv
// Audio output stage: optional DC blocker, volume/mute, 2nd-order sigma-delta 1-bit DAC.
// Define AUDIO_DCBLOCK_EN to build the DC-blocking high-pass; otherwise samples pass straight through.
module audio_dcblock_sdm #(
    parameter int unsigned DCB_SHIFT = 10,
    parameter int unsigned ACC_W     = 24
) (
    input logic                clock,
    input logic                reset_n,
    audio_dcblock_sdm_if.slave bus
);
    localparam int unsigned SumW = ACC_W + 2;
    localparam logic signed [SumW-1:0] AccMax = $signed({3'b000, {(ACC_W - 1){1'b1}}});
    localparam logic signed [SumW-1:0] AccMin = -AccMax;
    localparam logic signed [SumW-1:0] FbMag  = $signed({{(SumW - 17){1'b0}}, 17'h08000});

    if (ACC_W < 20) begin : g_bad_acc_w
        $error("ACC_W must be at least 20");
    end
    if (DCB_SHIFT < 1 || DCB_SHIFT > 15) begin : g_bad_dcb_shift
        $error("DCB_SHIFT must be in 1..15");
    end

    // ---------------------------------------------------------------------------------------
    // Stage 1: offset-binary to signed, optional DC removal
    // ---------------------------------------------------------------------------------------
    logic signed [15:0] x;
    logic signed [15:0] y_q;
    logic signed [15:0] y_d;
    logic               stage2_q;

    assign x = $signed(bus.sample_in ^ 16'h8000);

`ifdef AUDIO_DCBLOCK_EN
    logic signed [15:0] x_prev_q;
    logic signed [15:0] y_decay;
    logic signed [18:0] y_sum;
    logic               clip_d;
    logic               clip_q;

    assign y_decay = y_q >>> DCB_SHIFT;

    always_comb begin
        y_sum  = {{3{x[15]}}, x} - {{3{x_prev_q[15]}}, x_prev_q}
               + {{3{y_q[15]}}, y_q} - {{3{y_decay[15]}}, y_decay};
        y_d    = y_sum[15:0];
        clip_d = 1'b0;
        if (y_sum > 19'sd32767) begin
            y_d    = 16'sh7fff;
            clip_d = 1'b1;
        end else if (y_sum < -19'sd32768) begin
            y_d    = 16'sh8000;
            clip_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_prev_q <= '0;
            clip_q   <= 1'b0;
        end else begin
            // clip is a pulse: cleared on every edge without a strobe
            clip_q <= bus.sample_ce & clip_d;
            if (bus.sample_ce) begin
                x_prev_q <= x;
            end
        end
    end

    assign bus.clip = clip_q;
`else
    assign y_d      = x;
    assign bus.clip = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            y_q      <= '0;
            stage2_q <= 1'b0;
        end else begin
            stage2_q <= bus.sample_ce;
            if (bus.sample_ce) begin
                y_q <= y_d;
            end
        end
    end

    // ---------------------------------------------------------------------------------------
    // Stage 2: volume and mute, one cycle after the strobe
    // ---------------------------------------------------------------------------------------
    logic signed [5:0]  gain;
    logic signed [21:0] scaled;
    logic signed [15:0] level_q;
    logic signed [15:0] level_d;

    assign gain   = $signed({2'b00, bus.volume} + 6'd1);
    assign scaled = $signed({{6{y_q[15]}}, y_q}) * $signed({{16{1'b0}}, gain});

    // |y * gain| <= 2^19, so bits [19:4] hold the arithmetic >>> 4 exactly
    always_comb begin
        level_d = level_q;
        if (stage2_q) begin
            level_d = bus.mute ? 16'sd0 : scaled[19:4];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign bus.level_out = level_q;

    // ---------------------------------------------------------------------------------------
    // Modulator: two saturating integrators, 1-bit quantiser, full clock rate
    // ---------------------------------------------------------------------------------------
    logic signed [ACC_W-1:0] acc1_q;
    logic signed [ACC_W-1:0] acc1_d;
    logic signed [ACC_W-1:0] acc2_q;
    logic signed [ACC_W-1:0] acc2_d;
    logic signed [SumW-1:0]  fb;
    logic signed [SumW-1:0]  sum1;
    logic signed [SumW-1:0]  sum2;
    logic                    dac_q;

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SumW-1:0] v);
        if (v > AccMax) begin
            return AccMax[ACC_W-1:0];
        end else if (v < AccMin) begin
            return AccMin[ACC_W-1:0];
        end
        return v[ACC_W-1:0];
    endfunction

    always_comb begin
        fb     = dac_q ? FbMag : -FbMag;
        sum1   = {{2{acc1_q[ACC_W-1]}}, acc1_q} + {{(SumW - 16){level_q[15]}}, level_q} - fb;
        acc1_d = sat_acc(sum1);
        sum2   = {{2{acc2_q[ACC_W-1]}}, acc2_q} + {{2{acc1_d[ACC_W-1]}}, acc1_d} - fb;
        acc2_d = sat_acc(sum2);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc1_q <= '0;
            acc2_q <= '0;
            dac_q  <= 1'b0;
        end else begin
            acc1_q <= acc1_d;
            acc2_q <= acc2_d;
            dac_q  <= ~acc2_d[ACC_W-1];
        end
    end

    assign bus.dac_out = dac_q;
endmodule
